toggle_pulse_gen: RTL

//  Upstream stage for the T flip-flop (FFT). Turns a raw, bouncing push-button level into

---
 rtl/toggle_pulse_gen_pkg.sv | 23 ++
 rtl/toggle_pulse_gen_if.sv | 42 ++++
 rtl/toggle_pulse_gen_sync_2ff.sv | 32 +++
 rtl/toggle_pulse_gen.sv | 126 ++++++++++++
 4 files changed

// File: rtl/toggle_pulse_gen_pkg.sv
// ---------------------------------------------------------------------------
// toggle_pulse_gen_pkg
//   Shared definitions for the push-button toggle pulse generator:
//   FSM state encoding and default timing constants.
// ---------------------------------------------------------------------------
package toggle_pulse_gen_pkg;

    // Encoding is visible on the STATE debug output, so values are fixed.
    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_e;

    // Consecutive stable samples needed to accept a press or a release.
    localparam int DB_CYCLES_DEF  = 4;
    localparam int DB_W_DEF       = 3;
    // Auto-repeat period while the button is held.
    localparam int REP_CYCLES_DEF = 8;
    localparam int REP_W_DEF      = 4;

endpackage : toggle_pulse_gen_pkg

// File: rtl/toggle_pulse_gen_if.sv
// ---------------------------------------------------------------------------
// toggle_pulse_gen_if
//   Bundles the button-side inputs and the FFT-side outputs of the pulse
//   generator.
//     BTN       raw asynchronous button level (1 = pressed)
//     REPEAT_EN 1 = emit repeat pulses while held
//     T         one-cycle toggle request to the FFT
//     ENABLE    enable to the FFT
//     PRESSED   debounced button level
//     STATE     current FSM state (debug)
//   Handshake: there is no valid/ready pair. T is a single-cycle strobe that
//   the consumer must act on in the cycle it is high; ENABLE qualifies it.
//   master = stimulus/consumer side, slave = the generator itself.
// ---------------------------------------------------------------------------
interface toggle_pulse_gen_if;

    logic       BTN;
    logic       REPEAT_EN;
    logic       T;
    logic       ENABLE;
    logic       PRESSED;
    logic [1:0] STATE;

    modport master (
        output BTN,
        output REPEAT_EN,
        input  T,
        input  ENABLE,
        input  PRESSED,
        input  STATE
    );

    modport slave (
        input  BTN,
        input  REPEAT_EN,
        output T,
        output ENABLE,
        output PRESSED,
        output STATE
    );

endinterface : toggle_pulse_gen_if

// File: rtl/toggle_pulse_gen_sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
//   Two-flop synchronizer for a single asynchronous level. Reusable for any
//   slow asynchronous input.
//     CLK  clock
//     RST  synchronous active-high reset, clears both stages
//     D    asynchronous input
//     Q    synchronized output (two CLK edges of latency)
// ---------------------------------------------------------------------------
module sync_2ff (
    input  logic CLK,
    input  logic RST,
    input  logic D,
    output logic Q
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= D;
            s2_q <= s1_q;
        end
    end

    assign Q = s2_q;

endmodule : sync_2ff

// File: rtl/toggle_pulse_gen.sv
// ---------------------------------------------------------------------------
// toggle_pulse_gen
//   Turns a raw bouncing push-button level into clean toggle requests for a
//   T flip-flop: synchronize -> debounce -> press FSM -> one-cycle T pulse,
//   with optional auto-repeat while the button is held.
//     CLK   clock, all logic on the rising edge
//     RST   synchronous active-high reset
//     io    toggle_pulse_gen_if.slave (BTN, REPEAT_EN in; T, ENABLE,
//           PRESSED, STATE out)
// ---------------------------------------------------------------------------
module toggle_pulse_gen
    import toggle_pulse_gen_pkg::*;
#(
    parameter int DB_CYCLES  = DB_CYCLES_DEF,
    parameter int DB_W       = DB_W_DEF,
    parameter int REP_CYCLES = REP_CYCLES_DEF,
    parameter int REP_W      = REP_W_DEF
) (
    input  logic               CLK,
    input  logic               RST,
    toggle_pulse_gen_if.slave  io
);

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES - 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REP_CYCLES - 1);

    logic btn_s;

    state_e            state_q,   state_d;
    logic [DB_W-1:0]   db_cnt_q,  db_cnt_d;
    logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;
    logic              t_q,       t_d;
    logic              enable_q,  enable_d;

    sync_2ff u_sync (
        .CLK (CLK),
        .RST (RST),
        .D   (io.BTN),
        .Q   (btn_s)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            db_cnt_q  <= '0;
            rep_cnt_q <= '0;
            t_q       <= 1'b0;
            enable_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            db_cnt_q  <= db_cnt_d;
            rep_cnt_q <= rep_cnt_d;
            t_q       <= t_d;
            enable_q  <= enable_d;
        end
    end

    // Counters are cleared on every state entry and compared for equality,
    // so they never need to wrap.
    always_comb begin
        state_d   = state_q;
        db_cnt_d  = db_cnt_q;
        rep_cnt_d = rep_cnt_q;
        t_d       = 1'b0;
        enable_d  = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (btn_s) begin
                    state_d  = ST_PRESS_WAIT;
                    db_cnt_d = '0;
                end
            end

            ST_PRESS_WAIT: begin
                if (!btn_s) begin
                    state_d = ST_IDLE;          // bounce rejected
                end else if (db_cnt_q == DB_LAST) begin
                    state_d   = ST_HELD;
                    t_d       = 1'b1;
                    rep_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end

            ST_HELD: begin
                if (!btn_s) begin
                    state_d  = ST_RELEASE_WAIT;
                    db_cnt_d = '0;
                end else if (io.REPEAT_EN) begin
                    if (rep_cnt_q == REP_LAST) begin
                        t_d       = 1'b1;
                        rep_cnt_d = '0;
                    end else begin
                        rep_cnt_d = rep_cnt_q + REP_W'(1);
                    end
                end else begin
                    rep_cnt_d = '0;
                end
            end

            ST_RELEASE_WAIT: begin
                if (btn_s) begin
                    // Release bounce: resume holding without a new pulse.
                    state_d   = ST_HELD;
                    rep_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign io.T       = t_q;
    assign io.ENABLE  = enable_q;
    assign io.PRESSED = (state_q == ST_HELD) || (state_q == ST_RELEASE_WAIT);
    assign io.STATE   = state_q;

endmodule : toggle_pulse_gen
